// File: rtl/pmu_regif_pkg.sv
// -----------------------------------------------------------------------------
// pmu_regif_pkg
// Shared types and helpers for the PMU APB register front-end.
//   state_t    : two-state access FSM (IDLE waits for an access, RESP answers)
//   STRB_WIDTH : byte strobes per bus word
//   byte_merge : replace the strobed bytes of old_word with those of new_word
// The helper is sized for the PMU's 32-bit register width.
// -----------------------------------------------------------------------------
package pmu_regif_pkg;

   localparam int PMU_REG_WIDTH = 32;
   localparam int STRB_WIDTH    = PMU_REG_WIDTH / 8;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   function automatic logic [PMU_REG_WIDTH-1:0] byte_merge(
      input logic [PMU_REG_WIDTH-1:0] old_word,
      input logic [PMU_REG_WIDTH-1:0] new_word,
      input logic [STRB_WIDTH-1:0]    strb
   );
      logic [PMU_REG_WIDTH-1:0] merged;
      merged = old_word;
      for (int b = 0; b < STRB_WIDTH; b++) begin
         if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/pmu_apb_regif.sv
// -----------------------------------------------------------------------------
// pmu_apb_regif
// APB slave front-end for the PMU_raw register file. Every transfer takes one
// wait state. A valid write turns into a single-cycle wrapper_we_o pulse during
// which regs_o carries the live PMU image with only the addressed word replaced
// by the byte-merged write data. Reads return regs_i[idx] sampled at the edge
// that ends the wait state.
//
// Ports
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   psel_i, penable_i    : APB select / enable
//   pwrite_i             : 1 = write
//   paddr_i              : byte address, word index = paddr_i[ADDR_WIDTH-1:2]
//   pwdata_i, pstrb_i    : write data and byte strobes
//   pready_o             : transfer complete (registered)
//   prdata_o, pslverr_o  : read data / error, valid while pready_o is high
//   regs_i               : live PMU register image
//   regs_o               : image the PMU loads while wrapper_we_o is high
//   wrapper_we_o         : one-cycle load strobe to the PMU
// -----------------------------------------------------------------------------
module pmu_apb_regif
   import pmu_regif_pkg::*;
#(
   parameter int REG_WIDTH  = PMU_REG_WIDTH,
   parameter int N_REGS     = 47,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [ADDR_WIDTH-1:0] paddr_i,
   input  logic [REG_WIDTH-1:0]  pwdata_i,
   input  logic [STRB_WIDTH-1:0] pstrb_i,
   output logic                  pready_o,
   output logic [REG_WIDTH-1:0]  prdata_o,
   output logic                  pslverr_o,
   input  logic [REG_WIDTH-1:0]  regs_i [N_REGS],
   output logic [REG_WIDTH-1:0]  regs_o [N_REGS],
   output logic                  wrapper_we_o
);

   localparam int IDX_WIDTH = ADDR_WIDTH - 2;

   state_t                state_q;
   logic [IDX_WIDTH-1:0]  idx_q;
   logic [REG_WIDTH-1:0]  wdata_q;
   logic [STRB_WIDTH-1:0] strb_q;
   logic                  we_q;
   logic                  pready_q;
   logic                  pslverr_q;
   logic [REG_WIDTH-1:0]  prdata_q;

   logic [IDX_WIDTH-1:0]  addr_idx;
   logic                  addr_err;
   logic                  access;
   logic [REG_WIDTH-1:0]  rd_word;

   assign addr_idx = paddr_i[ADDR_WIDTH-1:2];
   assign addr_err = (paddr_i[1:0] != 2'b00) || (int'(addr_idx) >= N_REGS);
   // Masking with pready_q keeps the ready cycle from being seen as a new access.
   assign access   = psel_i & penable_i & ~pready_q;

   // Compare-based read mux: an out-of-range index simply selects nothing.
   always_comb begin
      // NOTE: assign a default before any conditional update so no path leaves
      // the signal unassigned and no latch is inferred.
      rd_word = '0;
      for (int k = 0; k < N_REGS; k++) begin
         if (addr_idx == IDX_WIDTH'(k)) rd_word = regs_i[k];
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         we_q      <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values
         // regardless of statement order.
         case (state_q)
            IDLE: begin
               if (access) begin
                  idx_q     <= addr_idx;
                  wdata_q   <= pwdata_i;
                  strb_q    <= pstrb_i;
                  pslverr_q <= addr_err;
                  pready_q  <= 1'b1;
                  we_q      <= pwrite_i & ~addr_err;
                  if (!pwrite_i) prdata_q <= addr_err ? '0 : rd_word;
                  state_q   <= RESP;
               end
            end
            RESP: begin
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               we_q      <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Unstrobed bytes and all other words pass straight through from the live
   // image, so a load never rolls back anything the PMU advanced meanwhile.
   always_comb begin
      for (int k = 0; k < N_REGS; k++) begin
         regs_o[k] = regs_i[k];
         if (we_q && (idx_q == IDX_WIDTH'(k))) begin
            regs_o[k] = byte_merge(regs_i[k], wdata_q, strb_q);
         end
      end
   end

   assign wrapper_we_o = we_q;
   assign pready_o     = pready_q;
   assign pslverr_o    = pslverr_q;
   assign prdata_o     = prdata_q;

endmodule

// File: tb/tb_pmu_apb_regif.sv
// -----------------------------------------------------------------------------
// tb_pmu_apb_regif
// Directed APB transfers against pmu_apb_regif. Each transfer pushes its
// hand-computed expected response into a queue; a monitor on the falling edge
// pops one entry whenever pready_o is high and compares the response and the
// regs_o image. Reset-abort cases are checked inline.
// -----------------------------------------------------------------------------
module tb_pmu_apb_regif;

   localparam int RW = 32;
   localparam int NR = 47;
   localparam int AW = 8;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic          psel_i;
   logic          penable_i;
   logic          pwrite_i;
   logic [AW-1:0] paddr_i;
   logic [RW-1:0] pwdata_i;
   logic [3:0]    pstrb_i;
   logic          pready_o;
   logic [RW-1:0] prdata_o;
   logic          pslverr_o;
   logic [RW-1:0] regs_i [NR];
   logic [RW-1:0] regs_o [NR];
   logic          wrapper_we_o;

   pmu_apb_regif #(.REG_WIDTH(RW), .N_REGS(NR), .ADDR_WIDTH(AW)) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .psel_i      (psel_i),
      .penable_i   (penable_i),
      .pwrite_i    (pwrite_i),
      .paddr_i     (paddr_i),
      .pwdata_i    (pwdata_i),
      .pstrb_i     (pstrb_i),
      .pready_o    (pready_o),
      .prdata_o    (prdata_o),
      .pslverr_o   (pslverr_o),
      .regs_i      (regs_i),
      .regs_o      (regs_o),
      .wrapper_we_o(wrapper_we_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          wr;
      bit          err;
      logic [31:0] rdata;
      int          idx;
      logic [31:0] word;
   } exp_t;

   exp_t sb[$];
   int   pulse_cyc[$];
   int   n_cmp      = 0;
   int   n_bad      = 0;
   int   pulses     = 0;
   int   exp_pulses = 0;
   int   cyc        = 0;

   always @(posedge clk_i) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Number of regs_o words that differ from the live regs_i image.
   function automatic int count_diff();
      int n = 0;
      for (int k = 0; k < NR; k++) if (regs_o[k] !== regs_i[k]) n++;
      return n;
   endfunction

   // Monitor / scoreboard
   always @(negedge clk_i) begin
      exp_t        e;
      int          n_diff;
      logic [31:0] want;
      if (rstn_i) begin
         if (wrapper_we_o) begin
            pulses++;
            pulse_cyc.push_back(cyc);
         end
         if (pready_o) begin
            if (sb.size() == 0) begin
               check("unexpected pready", {31'b0, pready_o}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("pslverr", {31'b0, pslverr_o}, {31'b0, e.err});
               check("wrapper_we", {31'b0, wrapper_we_o}, {31'b0, (e.wr && !e.err)});
               if (!e.wr) check("prdata", prdata_o, e.rdata);
               if (e.wr && !e.err) check("regs_o[idx]", regs_o[e.idx], e.word);
               n_diff = 0;
               for (int k = 0; k < NR; k++) begin
                  want = (e.wr && !e.err && k == e.idx) ? e.word : regs_i[k];
                  if (regs_o[k] !== want) n_diff++;
               end
               check("regs_o words wrong", n_diff, 0);
            end
         end
      end
   end

   task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input bit exp_err, input logic [31:0] exp_val);
      exp_t e;
      bit   got;
      int   waited;
      e.wr = wr; e.err = exp_err; e.rdata = exp_val; e.word = exp_val; e.idx = int'(addr[7:2]);
      sb.push_back(e);
      if (wr && !exp_err) exp_pulses++;
      @(posedge clk_i); #1;
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
      paddr_i = addr; pwdata_i = wdata; pstrb_i = strb;
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      got = 1'b0;
      waited = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk_i); #1;
         waited++;
         if (pready_o) got = 1'b1;
      end
      check("pready seen", {31'b0, got}, 32'd1);
      check("cycles to pready", waited, 1);
   endtask

   task automatic apb_idle();
      @(posedge clk_i); #1;
      psel_i = 1'b0; penable_i = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " pready"},  {31'b0, pready_o}, 32'd0);
      check({tag, " pslverr"}, {31'b0, pslverr_o}, 32'd0);
      check({tag, " prdata"},  prdata_o, 32'd0);
      check({tag, " we"},      {31'b0, wrapper_we_o}, 32'd0);
      check({tag, " regs_o passthrough"}, count_diff(), 0);
   endtask

   initial begin
      int base;
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      rstn_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
      paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
      for (int k = 0; k < NR; k++) regs_i[k] = 32'hA500_0000 | k;
      regs_i[29] = 32'h0000_003C;
      regs_i[30] = 32'h1122_3344;

      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_outputs_zero("reset");
      @(posedge clk_i); #1;
      rstn_i = 1'b1;

      // full write, partial write, read
      apb_xfer(1, 8'h00, 32'h0000_0012, 4'hF, 0, 32'h0000_0012);
      apb_xfer(1, 8'h78, 32'hAABB_CCDD, 4'b0011, 0, 32'h1122_CCDD);
      apb_xfer(0, 8'h74, 32'h0, 4'h0, 0, 32'h0000_003C);
      // errors: out-of-range write, misaligned read after nonzero read data
      apb_xfer(1, 8'hBC, 32'hFFFF_FFFF, 4'hF, 1, 32'h0);
      apb_xfer(0, 8'h02, 32'h0, 4'h0, 1, 32'h0);
      // zero-strobe write still pulses, word unchanged
      apb_xfer(1, 8'h14, 32'h1234_5678, 4'h0, 0, 32'hA500_0005);
      // misaligned write
      apb_xfer(1, 8'h01, 32'h1234_5678, 4'hF, 1, 32'h0);
      // last valid index read
      apb_xfer(0, 8'hB8, 32'h0, 4'h0, 0, 32'hA500_002E);

      // reset during the wait state of a write (prdata currently nonzero)
      @(posedge clk_i); #1;
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
      paddr_i = 8'h10; pwdata_i = 32'hDEAD_BEEF; pstrb_i = 4'hF;
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      #2 rstn_i = 1'b0;
      #1 check_outputs_zero("reset in T1");
      psel_i = 1'b0; penable_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rstn_i = 1'b1;
      repeat (3) @(posedge clk_i);

      // reset during the ready cycle of a write, after a read loaded prdata
      apb_xfer(0, 8'h74, 32'h0, 4'h0, 0, 32'h0000_003C);
      @(posedge clk_i); #1;
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
      paddr_i = 8'h18; pwdata_i = 32'h5A5A_5A5A; pstrb_i = 4'hF;
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      @(posedge clk_i); #1;
      check("T2 pready before reset", {31'b0, pready_o}, 32'd1);
      check("T2 we before reset", {31'b0, wrapper_we_o}, 32'd1);
      rstn_i = 1'b0;
      #1 check_outputs_zero("reset in T2");
      psel_i = 1'b0; penable_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rstn_i = 1'b1;
      repeat (3) @(posedge clk_i);

      // normal operation after reset
      apb_xfer(1, 8'h08, 32'h0000_0055, 4'hF, 0, 32'h0000_0055);
      apb_xfer(0, 8'h00, 32'h0, 4'h0, 0, 32'hA500_0000);
      apb_idle();

      // back-to-back writes to indices 43..46
      base = pulse_cyc.size();
      for (int k = 43; k <= 46; k++) begin
         apb_xfer(1, 8'(k * 4), 32'hCAFE_0000 + k, 4'hF, 0, 32'hCAFE_0000 + k);
      end
      apb_idle();
      repeat (2) @(posedge clk_i);
      check("b2b pulse count", pulse_cyc.size() - base, 4);
      if (pulse_cyc.size() - base == 4) begin
         for (int i = 1; i < 4; i++) begin
            check("b2b pulse spacing", pulse_cyc[base+i] - pulse_cyc[base+i-1], 3);
         end
      end

      repeat (4) @(posedge clk_i);
      check("scoreboard drained", sb.size(), 0);
      check("total pulses", pulses, exp_pulses);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
